fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end for the 5-stage RV32I core: it owns the PC, issues single-outstanding requests on the instruction bus (`iaddr`/`iready_n`/`idata`) and buffers returned words in a DEPTH-entry FIFO of {pc, pc+4, instr}. It sits between instruction memory and decode, replacing a single fetch pipeline register. Unlike that register, it decouples memory latency from decode stalls and cleanly discards in-flight fetches on branch redirect.

## Interface
- `DEPTH`, 4: queue entries; power of 2, ≥2.
- `XLEN`, 32: PC/address width.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` input 1: the single clock.
- `rst` input 1: reset, asynchronous, active-low.
- `iaddr` output XLEN: fetch address; held stable while a request is outstanding.
- `ireq` output 1: request outstanding.
- `iready_n` input 1: low means `idata` is valid for the current `iaddr`.
- `idata` input 32: instruction word.
- `redirect_en` input 1: branch/jump taken (from MEM); flushes the queue.
- `redirect_pc` input XLEN: redirect target.
- `keep` input 1: decode stall; no dequeue while high.
- `deq_valid` output 1: head entry valid.
- `deq_ready` input 1: decode accepts the head; effective only when `keep`=0.
- `deq_instr`, `deq_pc`, `deq_pcp4` output 32/XLEN/XLEN: head entry contents.
- `deq_rs1`, `deq_rs2`, `deq_rd` output 5 each: predecoded fields; see Configuration.
- `count` output $clog2(DEPTH)+1: occupancy.

## Operation
- Dequeue fires when `rd` = `deq_valid & deq_ready & ~keep`.
- Enqueue fires when `wr` = `state==WAIT & ~iready_n`. It writes {`idata`, `iaddr`, `iaddr`+4} at the tail.
- Space test: `space` = (`count` + `wr` − `rd`) < DEPTH. Because only one request is ever outstanding, an enqueue never finds the queue full.
- FSM states:
  - IDLE: no request.
    - `space` → WAIT.
  - WAIT: request to `iaddr` outstanding, `ireq`=1.
    - Response and `space` → WAIT, with `iaddr`+=4.
    - Response and no space → IDLE, with `iaddr`+=4.
    - `redirect_en` without response → DROP.
  - DROP: stale request outstanding, `ireq`=1. The response is discarded.
    - On response → IDLE, with `iaddr` loaded from the latched redirect target.
- `redirect_en` (any state):
  - Read/write pointers and `count` clear at the next edge.
  - A same-cycle `wr` and `rd` are suppressed.
  - In IDLE, `iaddr` loads `redirect_pc` directly.
  - In WAIT with a same-cycle response, the response is dropped, `iaddr` loads `redirect_pc`, and the next state is IDLE.
  - In WAIT without a response, or in DROP, the target is latched into `redir_pc_q` and the next state is DROP. In DROP, a later redirect overwrites `redir_pc_q`.
- `redirect_pc[1:0]` is forced to 0.
- Pointer arithmetic is modulo DEPTH and wraps naturally. `count` saturates by construction and never exceeds DEPTH.

## Timing
- Reset values:
  - `iaddr`=RESET_PC, state=IDLE, `ireq`=0.
  - `count`=0, `deq_valid`=0.
  - `deq_*` data outputs are 0; `deq_pcp4`=RESET_PC+4 is not required.
- First request: `ireq`=1 one cycle after reset release.
- Latency: response edge → `deq_valid`=1 on the following cycle. Head outputs are read from registered storage, with no bypass.
- Throughput: one instruction per cycle when the memory answers every cycle and the queue is not full.
- Reset asserted mid-request: everything returns to reset values immediately. The pending response is lost, and the bus must tolerate an abandoned request.

## Configuration
- `FETCH_QUEUE_PREDECODE_EN` defined:
  - `deq_rs1`/`deq_rs2`/`deq_rd` = `instr[19:15]`/`[24:20]`/`[11:7]` of the head entry.
  - Fields the opcode does not use are zeroed: rs2 for I/U/J/load, rs1 for U/J, rd for S/B.
  - These fields are computed at enqueue and stored per entry, so the hazard unit gets them registered.
- Not defined: the three ports are tied to 0 and no extra storage is built.

## Structure
- Shared package holds:
  - RV32I opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC).
  - The FSM state enum {IDLE, WAIT, DROP}.
  - The `fq_entry_t` struct {instr, pc, pcp4, rs1, rs2, rd}.
- One sub-module, `fq_predecode` (combinational field extractor), instantiated only under the macro.

## Test plan
- Reset release with memory answering every cycle, `deq_ready`=1 → `iaddr` 0,4,8,...; `deq_pc` follows with one-cycle lag; `count` ≤1.
- `keep`=1 for 10 cycles, DEPTH=4 → exactly 4 entries enqueued; `ireq` drops to 0; the 5th address is not requested until a dequeue.
- `iready_n` held high 5 cycles on `iaddr`=0x10, with `redirect_en` pulsed (`redirect_pc`=0x100) at cycle 2 → `iaddr` stays 0x10; the response is dropped; the next request is 0x100; no entry with pc 0x10 appears.
- Redirect on the same cycle as a response and a dequeue, with the queue holding 3 entries → `count`=0 next cycle; next `iaddr`=redirect target.
- Wrap test: 3×DEPTH enqueues with random `deq_ready` → in-order pcs, no loss or duplication; `count` never exceeds DEPTH.
- With the macro defined, enqueue `sw x5,0(x6)` (0x00532023) → `deq_rs1`=6, `deq_rs2`=5, `deq_rd`=0. Without the macro, all three read 0.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared opcodes, FSM states and queue entry layout for fetch_queue
package fetch_queue_pkg;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam int PC_W = 32;
    typedef enum logic [1:0] {IDLE, WAIT, DROP} fq_state_t;
    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pcp4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } fq_entry_t;
endpackage

// File: rtl/fq_predecode.sv
// fq_predecode: extracts register fields, zeroing those the opcode does not use
module fq_predecode
    import fetch_queue_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd
);
    logic [6:0] opc;
    logic       unused_bits;
    assign opc = instr[6:0];
    assign unused_bits = ^{instr[31:25], instr[14:12]};
    // field extraction with per-format masking
    always_comb begin
        rs1 = (opc == LUI || opc == AUIPC || opc == JAL) ? 5'd0 : instr[19:15];
        rs2 = (opc == OP_IMM || opc == LOAD || opc == JALR || opc == LUI || opc == AUIPC || opc == JAL) ? 5'd0 : instr[24:20];
        rd  = (opc == STORE || opc == BRANCH) ? 5'd0 : instr[11:7];
    end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner, single-outstanding fetch FSM and DEPTH-entry instruction FIFO (optional FETCH_QUEUE_PREDECODE_EN)
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int               DEPTH    = 4,
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [XLEN-1:0]        iaddr,
    output logic                   ireq,
    input  logic                   iready_n,
    input  logic [31:0]            idata,
    input  logic                   redirect_en,
    input  logic [XLEN-1:0]        redirect_pc,
    input  logic                   keep,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [31:0]            deq_instr,
    output logic [XLEN-1:0]        deq_pc,
    output logic [XLEN-1:0]        deq_pcp4,
    output logic [4:0]             deq_rs1,
    output logic [4:0]             deq_rs2,
    output logic [4:0]             deq_rd,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_state_t       state, state_d;
    logic [XLEN-1:0] iaddr_d, redir_pc_q, redir_pc_d, tgt;
    logic [AW-1:0]   wptr, rptr;
    logic            resp, wr, rd, space;
    logic [4:0]      pd_rs1, pd_rs2, pd_rd;
    logic            unused_ok;
    fq_entry_t       mem [DEPTH];
    fq_entry_t       wentry, head;

    assign tgt       = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_ok = ^redirect_pc[1:0];
    assign resp      = state != IDLE && !iready_n;
    assign wr        = state == WAIT && !iready_n && !redirect_en;
    assign rd        = deq_valid && deq_ready && !keep && !redirect_en;
    assign space     = ({1'b0, count} + (CW+1)'(wr) - (CW+1)'(rd)) < (CW+1)'(DEPTH);

`ifdef FETCH_QUEUE_PREDECODE_EN
    fq_predecode u_predecode (.instr(idata), .rs1(pd_rs1), .rs2(pd_rs2), .rd(pd_rd));
`else
    assign {pd_rs1, pd_rs2, pd_rd} = '0;
`endif

    // entry written at the tail on an accepted response
    always_comb begin
        wentry = '{instr: idata, pc: PC_W'(iaddr), pcp4: PC_W'(iaddr + XLEN'(4)),
                   rs1: pd_rs1, rs2: pd_rs2, rd: pd_rd};
    end

    // fetch FSM state, fetch address and latched redirect target
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            iaddr      <= RESET_PC;
            redir_pc_q <= '0;
        end else begin
            state      <= state_d;
            iaddr      <= iaddr_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    // next-state: issue when room remains, drop responses stranded by a redirect
    always_comb begin
        state_d    = state;
        iaddr_d    = iaddr;
        redir_pc_d = redir_pc_q;
        case (state)
            IDLE: begin
                if (redirect_en) iaddr_d = tgt;
                else if (space)  state_d = WAIT;
            end
            WAIT: begin
                if (redirect_en && resp) begin
                    state_d = IDLE;
                    iaddr_d = tgt;
                end else if (redirect_en) begin
                    state_d    = DROP;
                    redir_pc_d = tgt;
                end else if (resp) begin
                    state_d = space ? WAIT : IDLE;
                    iaddr_d = iaddr + XLEN'(4);
                end
            end
            DROP: begin
                if (resp) begin
                    state_d = IDLE;
                    iaddr_d = redirect_en ? tgt : redir_pc_q;
                end else if (redirect_en) begin
                    redir_pc_d = tgt;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // bus request and head-valid flags
    always_comb begin
        ireq      = state != IDLE;
        deq_valid = count != '0;
    end

    // queue pointers and occupancy; a redirect empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (redirect_en) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(wr);
            rptr  <= rptr + AW'(rd);
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    // entry storage, cleared on reset so head outputs start at zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[wptr] <= wentry;
        end
    end

    assign head      = mem[rptr];
    assign deq_instr = head.instr;
    assign deq_pc    = XLEN'(head.pc);
    assign deq_pcp4  = XLEN'(head.pcp4);
    assign deq_rs1   = head.rs1;
    assign deq_rs2   = head.rs2;
    assign deq_rd    = head.rd;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vectors and corner sequences for fetch_queue
module tb_fetch_queue;
    logic        clk = 0;
    logic        rst = 0;
    logic [31:0] iaddr;
    logic        ireq;
    logic        iready_n = 0;
    logic [31:0] idata;
    logic        redirect_en = 0;
    logic [31:0] redirect_pc = 0;
    logic        keep = 0;
    logic        deq_valid;
    logic        deq_ready = 1;
    logic [31:0] deq_instr, deq_pc, deq_pcp4;
    logic [4:0]  deq_rs1, deq_rs2, deq_rd;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        keep;
        logic        rdy;
        logic [31:0] e_iaddr;
        logic        e_ireq;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [2:0]  e_count;
    } vec_t;

    vec_t vt [19];

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a == 32'h200 ? 32'h00532023 : a == 32'h204 ? 32'h00510093 : ~a;
    endfunction

    function automatic vec_t mk(input logic k, input logic r, input logic [31:0] ia, input logic rq,
                                input logic v, input logic [31:0] pc, input logic [2:0] c);
        vec_t t;
        t.keep = k; t.rdy = r; t.e_iaddr = ia; t.e_ireq = rq; t.e_valid = v; t.e_pc = pc; t.e_count = c;
        return t;
    endfunction

    assign idata = memfn(iaddr);

    fetch_queue dut (
        .clk(clk), .rst(rst), .iaddr(iaddr), .ireq(ireq), .iready_n(iready_n), .idata(idata),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .keep(keep), .deq_valid(deq_valid),
        .deq_ready(deq_ready), .deq_instr(deq_instr), .deq_pc(deq_pc), .deq_pcp4(deq_pcp4),
        .deq_rs1(deq_rs1), .deq_rs2(deq_rs2), .deq_rd(deq_rd), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [14:0] e_sw, e_addi;
        logic [31:0] exp_pc;
        int          ndq;
        bit          found;
`ifdef FETCH_QUEUE_PREDECODE_EN
        e_sw   = {5'd6, 5'd5, 5'd0};
        e_addi = {5'd2, 5'd0, 5'd1};
`else
        e_sw   = '0;
        e_addi = '0;
`endif
        vt[0]  = mk(0, 1, 32'h00, 0, 0, 32'h00, 0);
        vt[1]  = mk(0, 1, 32'h00, 1, 0, 32'h00, 0);
        vt[2]  = mk(0, 1, 32'h04, 1, 1, 32'h00, 1);
        vt[3]  = mk(0, 1, 32'h08, 1, 1, 32'h04, 1);
        vt[4]  = mk(0, 1, 32'h0C, 1, 1, 32'h08, 1);
        vt[5]  = mk(1, 1, 32'h10, 1, 1, 32'h0C, 1);
        vt[6]  = mk(1, 1, 32'h14, 1, 1, 32'h0C, 2);
        vt[7]  = mk(1, 1, 32'h18, 1, 1, 32'h0C, 3);
        for (int i = 8; i < 15; i++) vt[i] = mk(1, 1, 32'h1C, 0, 1, 32'h0C, 4);
        vt[15] = mk(0, 1, 32'h1C, 0, 1, 32'h0C, 4);
        vt[16] = mk(0, 1, 32'h1C, 1, 1, 32'h10, 3);
        vt[17] = mk(0, 1, 32'h20, 1, 1, 32'h14, 3);
        vt[18] = mk(0, 1, 32'h24, 1, 1, 32'h18, 3);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_iaddr", iaddr, 0);
        chk("rst_ireq", ireq, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", deq_valid, 0);
        chk("rst_instr", deq_instr, 0);
        chk("rst_pc", deq_pc, 0);

        @(negedge clk);
        rst = 1;
        for (int i = 0; i < 19; i++) begin
            if (i > 0) @(negedge clk);
            keep = vt[i].keep;
            deq_ready = vt[i].rdy;
            #1;
            chk($sformatf("v%0d_iaddr", i), iaddr, vt[i].e_iaddr);
            chk($sformatf("v%0d_ireq", i), ireq, vt[i].e_ireq);
            chk($sformatf("v%0d_valid", i), deq_valid, vt[i].e_valid);
            chk($sformatf("v%0d_count", i), count, vt[i].e_count);
            if (vt[i].e_valid) begin
                chk($sformatf("v%0d_pc", i), deq_pc, vt[i].e_pc);
                chk($sformatf("v%0d_instr", i), deq_instr, memfn(vt[i].e_pc));
            end
        end

        @(negedge clk);
        #1;
        chk("midreq_ireq_before", ireq, 1);
        rst = 0;
        #1;
        chk("midreq_iaddr", iaddr, 0);
        chk("midreq_ireq", ireq, 0);
        chk("midreq_count", count, 0);
        chk("midreq_valid", deq_valid, 0);
        @(negedge clk);
        rst = 1;

        found = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (ireq && iaddr == 32'h10) begin
                found = 1;
                break;
            end
        end
        chk("find_0x10", found, 1);
        iready_n = 1;
        @(negedge clk);
        redirect_en = 1;
        redirect_pc = 32'h102;
        #1;
        chk("drop_c2_iaddr", iaddr, 32'h10);
        chk("drop_c2_ireq", ireq, 1);
        @(negedge clk);
        redirect_en = 0;
        #1;
        chk("drop_c3_iaddr", iaddr, 32'h10);
        chk("drop_c3_ireq", ireq, 1);
        chk("drop_c3_count", count, 0);
        chk("drop_c3_valid", deq_valid, 0);
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("drop_hold_iaddr", iaddr, 32'h10);
            chk("drop_hold_ireq", ireq, 1);
        end
        @(negedge clk);
        iready_n = 0;
        #1;
        chk("drop_resp_iaddr", iaddr, 32'h10);
        @(negedge clk);
        #1;
        chk("drop_after_iaddr", iaddr, 32'h100);
        chk("drop_after_ireq", ireq, 0);
        chk("drop_after_valid", deq_valid, 0);
        @(negedge clk);
        #1;
        chk("redir_req_iaddr", iaddr, 32'h100);
        chk("redir_req_ireq", ireq, 1);
        chk("redir_req_valid", deq_valid, 0);
        @(negedge clk);
        #1;
        chk("redir_head_valid", deq_valid, 1);
        chk("redir_head_pc", deq_pc, 32'h100);
        chk("redir_head_instr", deq_instr, memfn(32'h100));

        keep = 1;
        found = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            if (count == 3) begin
                found = 1;
                break;
            end
        end
        chk("fill3", found, 1);
        keep = 0;
        redirect_en = 1;
        redirect_pc = 32'h200;
        #1;
        chk("rsame_ireq", ireq, 1);
        @(negedge clk);
        redirect_en = 0;
        #1;
        chk("rsame_count", count, 0);
        chk("rsame_valid", deq_valid, 0);
        chk("rsame_iaddr", iaddr, 32'h200);
        chk("rsame_ireq_after", ireq, 0);
        @(negedge clk);
        #1;
        chk("rsame_req_iaddr", iaddr, 32'h200);
        chk("rsame_req_ireq", ireq, 1);
        @(negedge clk);
        #1;
        chk("sw_valid", deq_valid, 1);
        chk("sw_pc", deq_pc, 32'h200);
        chk("sw_pcp4", deq_pcp4, 32'h204);
        chk("sw_instr", deq_instr, 32'h00532023);
        chk("sw_fields", {deq_rs1, deq_rs2, deq_rd}, e_sw);
        @(negedge clk);
        #1;
        chk("addi_pc", deq_pc, 32'h204);
        chk("addi_instr", deq_instr, 32'h00510093);
        chk("addi_fields", {deq_rs1, deq_rs2, deq_rd}, e_addi);

        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        exp_pc = 0;
        ndq = 0;
        for (int c = 0; c < 400 && ndq < 12; c++) begin
            @(negedge clk);
            deq_ready = 1'($urandom_range(0, 1));
            iready_n = $urandom_range(0, 3) == 0;
            #1;
            chk("wrap_count_le_depth", count <= 3'd4, 1);
            if (deq_valid && deq_ready) begin
                chk("wrap_pc", deq_pc, exp_pc);
                chk("wrap_instr", deq_instr, memfn(exp_pc));
                exp_pc += 4;
                ndq++;
            end
        end
        chk("wrap_dequeued", ndq, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
